// File: rtl/radix_net_pkg.sv
// Shared widths, Booth digit encoding and window decoder for the radix-4 multiplier.
// RADIX_NET_SIGNED_EN selects two's-complement operands (two digits) instead of unsigned (three).
package radix_net_pkg;

  localparam int OPW = 4;
  localparam int PRW = 8;
`ifdef RADIX_NET_SIGNED_EN
  localparam int NDIG = 2;
`else
  localparam int NDIG = 3;
`endif

  typedef enum logic [2:0] {
    BD_ZERO,
    BD_P1,
    BD_P2,
    BD_M1,
    BD_M2
  } booth_digit_e;

  // Window is {y[2i+1], y[2i], y[2i-1]}.
  function automatic booth_digit_e booth_decode(input logic [2:0] win);
    booth_digit_e dig;
    case (win)
      3'b001, 3'b010: dig = BD_P1;
      3'b011:         dig = BD_P2;
      3'b100:         dig = BD_M2;
      3'b101, 3'b110: dig = BD_M1;
      default:        dig = BD_ZERO;
    endcase
    return dig;
  endfunction

endpackage

// File: rtl/radix_net_booth_enc.sv
// Combinational Booth digit encoder: one 3-bit multiplier window times the
// extended multiplicand, returned as an unshifted 8-bit two's-complement partial product.
module radix_net_booth_enc
  import radix_net_pkg::*;
(
  input  logic [2:0]     win,
  input  logic [PRW-1:0] x_ext,
  output logic [PRW-1:0] pp
);

  booth_digit_e dig;

  always_comb begin
    dig = booth_decode(win);
    pp  = '0;
    case (dig)
      BD_P1:   pp = x_ext;
      BD_P2:   pp = x_ext << 1;
      BD_M1:   pp = ~x_ext + PRW'(1);
      BD_M2:   pp = ~(x_ext << 1) + PRW'(1);
      default: pp = '0;
    endcase
  end

endmodule

// File: rtl/radix_net_booth_multiplier.sv
// Two-stage pipelined 4x4 radix-4 Booth multiplier: stage 1 registers shifted partial
// products, stage 2 registers their sum. RADIX_NET_SIGNED_EN enables signed operands.
module radix_net_booth_multiplier
  import radix_net_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  input  logic [OPW-1:0] x,
  input  logic [OPW-1:0] y,
  output logic [PRW-1:0] out
);

  logic [PRW-1:0]            x_ext;
  logic [2*NDIG:0]           y_win;
  logic [NDIG-1:0][PRW-1:0]  pp_d;
  logic [NDIG-1:0][PRW-1:0]  pp_q;
  logic [PRW-1:0]            out_d;
  logic [PRW-1:0]            out_q;

  // y_win[0] is the implicit y[-1]=0; unsigned mode zero-extends y to feed the third digit.
  always_comb begin
`ifdef RADIX_NET_SIGNED_EN
    x_ext = {{(PRW-OPW){x[OPW-1]}}, x};
    y_win = {y, 1'b0};
`else
    x_ext = {{(PRW-OPW){1'b0}}, x};
    y_win = {2'b00, y, 1'b0};
`endif
  end

  genvar gi;
  generate
    for (gi = 0; gi < NDIG; gi++) begin : g_dig
      logic [PRW-1:0] pp_raw;

      radix_net_booth_enc u_enc (
        .win   (y_win[2*gi+2:2*gi]),
        .x_ext (x_ext),
        .pp    (pp_raw)
      );

      assign pp_d[gi] = pp_raw << (2*gi);
    end
  endgenerate

  always_comb begin
    out_d = '0;
    for (int i = 0; i < NDIG; i++) begin
      out_d = out_d + pp_q[i];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pp_q  <= '0;
      out_q <= '0;
    end else begin
      pp_q  <= pp_d;
      out_q <= out_d;
    end
  end

  assign out = out_q;

endmodule

// File: tb/tb_radix_net_booth_multiplier.sv
// Directed and exhaustive self-checking bench for radix_net_booth_multiplier; expected
// products are hand-computed constants or a reference product, delayed two edges.
module tb_radix_net_booth_multiplier;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] x = '0;
  logic [3:0] y = '0;
  logic [7:0] out;

  int n_checks = 0;
  int n_pass   = 0;

  // Expected contents of the stage-1 register and of out.
  logic [7:0] s1_m  = '0;
  logic [7:0] out_m = '0;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [7:0] p;
  } vec_t;

  vec_t vecs [8];

  radix_net_booth_multiplier dut (
    .clk   (clk),
    .reset (reset),
    .x     (x),
    .y     (y),
    .out   (out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: out=%02h expected=%02h", tag, got, exp);
  endtask

  // Called at a falling edge: drive inputs, let one rising edge pass, check at the next falling edge.
  task automatic tick(input string tag, input logic r, input logic [3:0] xv, input logic [3:0] yv,
                      input logic [7:0] expv);
    reset = r;
    x     = xv;
    y     = yv;
    @(posedge clk);
    out_m = r ? s1_m : 8'h00;
    s1_m  = r ? expv : 8'h00;
    @(negedge clk);
    $display("%s reset=%b x=%h y=%h out=%02h exp=%02h", tag, r, xv, yv, out, out_m);
    check(tag, out, out_m);
  endtask

  function automatic logic [7:0] ref_prod(input logic [3:0] a, input logic [3:0] b);
`ifdef RADIX_NET_SIGNED_EN
    int sa = $signed(a);
    int sb = $signed(b);
`else
    int sa = int'(a);
    int sb = int'(b);
`endif
    return 8'(sa * sb);
  endfunction

  initial begin
`ifdef RADIX_NET_SIGNED_EN
    vecs[0] = '{4'hF, 4'hF, 8'h01};
    vecs[1] = '{4'h8, 4'h8, 8'h40};
    vecs[2] = '{4'h8, 4'h7, 8'hC8};
    vecs[3] = '{4'h7, 4'hD, 8'hEB};
    vecs[4] = '{4'h1, 4'h8, 8'hF8};
`else
    vecs[0] = '{4'hF, 4'hF, 8'hE1};
    vecs[1] = '{4'hF, 4'h0, 8'h00};
    vecs[2] = '{4'h1, 4'h8, 8'h08};
    vecs[3] = '{4'h9, 4'hA, 8'h5A};
    vecs[4] = '{4'h7, 4'h3, 8'h15};
`endif
    vecs[5] = '{4'h2, 4'h3, 8'h06};
    vecs[6] = '{4'h4, 4'h5, 8'h14};
    vecs[7] = '{4'h6, 4'h7, 8'h2A};

    @(negedge clk);
    for (int i = 0; i < 3; i++) tick("reset_hold", 1'b0, 4'h7, 4'h3, 8'h15);
    for (int i = 0; i < 4; i++) tick("release_7x3", 1'b1, 4'h7, 4'h3, 8'h15);

    for (int i = 0; i < 8; i++) tick("directed", 1'b1, vecs[i].a, vecs[i].b, vecs[i].p);

    // Reset with two products in flight must discard them.
    tick("flush_reset", 1'b0, 4'h3, 4'h3, 8'h09);
    tick("after_flush", 1'b1, 4'h2, 4'h2, 8'h04);
    tick("after_flush", 1'b1, 4'h0, 4'h0, 8'h00);
    tick("after_flush", 1'b1, 4'h0, 4'h0, 8'h00);

    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        tick("sweep", 1'b1, 4'(a), 4'(b), ref_prod(4'(a), 4'(b)));
      end
    end
    tick("drain", 1'b1, 4'h0, 4'h0, 8'h00);
    tick("drain", 1'b1, 4'h0, 4'h0, 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
